// File: rtl/eth_fcs_check_d16.sv
// Receive-side Ethernet FCS checker for a 16-bit byte stream (FCS bytes included).
// Forwards accepted beats one cycle late and reports per-frame status and good/bad counts.

module eth_crc32_d16 (
  input  logic [31:0] crc_in,
  input  logic [15:0] data,
  output logic [31:0] crc_out
);
  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic [31:0] work;

  // MSB-first shift register: data[15] is the first bit on the wire
  always_comb begin
    work = crc_in;
    for (int i = 15; i >= 0; i--) begin
      if (work[31] ^ data[i]) begin
        work = {work[30:0], 1'b0} ^ POLY;
      end else begin
        work = {work[30:0], 1'b0};
      end
    end
    crc_out = work;
  end
endmodule

module eth_fcs_check_d16 #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic             in_eof,
  input  logic             in_odd,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eof,
  output logic             out_odd,
  output logic [15:0]      out_data,
  output logic             stat_valid,
  output logic             stat_fcs_ok,
  output logic             stat_len_err,
  output logic             stat_abort,
  output logic [15:0]      stat_len,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);
  localparam logic [31:0]      POLY      = 32'h04C1_1DB7;
  localparam logic [31:0]      CRC_SEED  = 32'hFFFF_FFFF;
  localparam logic [31:0]      RESIDUE   = 32'hC704_DD7B;
  localparam logic [15:0]      MIN_LEN_W = 16'(MIN_LEN);
  localparam logic [15:0]      MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] crc_reg, crc_next;
  logic [15:0] len_reg, len_next;

  function automatic logic [31:0] crc32_d8(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[31] ^ d[i]) begin
        c = {c[30:0], 1'b0} ^ POLY;
      end else begin
        c = {c[30:0], 1'b0};
      end
    end
    return c;
  endfunction

  // Bytes arrive LSB first on the wire, so each byte is bit-reversed into the MSB-first engine
  logic [7:0] rev_lo, rev_hi;
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rev
      assign rev_lo[gi] = in_data[7 - gi];
      assign rev_hi[gi] = in_data[15 - gi];
    end
  endgenerate

  logic [31:0] seed, crc_d16, crc_d8, crc_beat;
  assign seed = in_sof ? CRC_SEED : crc_reg;

  eth_crc32_d16 u_crc16 (
    .crc_in  (seed),
    .data    ({rev_lo, rev_hi}),
    .crc_out (crc_d16)
  );

  logic last_odd, accept, abort_now;
  assign last_odd  = in_eof & in_odd;
  assign crc_d8    = crc32_d8(seed, rev_lo);
  assign crc_beat  = last_odd ? crc_d8 : crc_d16;
  assign accept    = in_valid & (in_sof | (state_reg == ACTIVE));
  assign abort_now = in_valid & in_sof & (state_reg == ACTIVE);

  logic [15:0] len_base, len_beat;
  logic [16:0] len_sum;
  logic        beat_len_err, reg_len_err;
  assign len_base     = in_sof ? 16'd0 : len_reg;
  assign len_sum      = {1'b0, len_base} + (last_odd ? 17'd1 : 17'd2);
  assign len_beat     = len_sum[16] ? 16'hFFFF : len_sum[15:0];
  assign beat_len_err = (len_beat < MIN_LEN_W) | (len_beat > MAX_LEN_W);
  assign reg_len_err  = (len_reg < MIN_LEN_W) | (len_reg > MAX_LEN_W);

  logic        fire, fire_ok, fire_abort, fire_len_err, good_inc;
  logic [15:0] fire_len;
  logic [1:0]  bad_inc;

  always_comb begin
    state_next   = state_reg;
    crc_next     = crc_reg;
    len_next     = len_reg;
    fire         = 1'b0;
    fire_ok      = 1'b0;
    fire_abort   = 1'b0;
    fire_len_err = 1'b0;
    fire_len     = len_reg;
    good_inc     = 1'b0;
    bad_inc      = 2'd0;
    if (accept) begin
      if (in_eof) begin
        state_next = IDLE;
        crc_next   = CRC_SEED;
        len_next   = 16'd0;
      end else begin
        state_next = ACTIVE;
        crc_next   = crc_beat;
        len_next   = len_beat;
      end
      if (abort_now) begin
        // The abort owns the status pulse; a single-beat new frame is only counted
        fire         = 1'b1;
        fire_abort   = 1'b1;
        fire_len     = len_reg;
        fire_len_err = reg_len_err;
        bad_inc      = in_eof ? 2'd2 : 2'd1;
      end else if (in_eof) begin
        fire         = 1'b1;
        fire_ok      = (crc_beat == RESIDUE);
        fire_len     = len_beat;
        fire_len_err = beat_len_err;
        if ((crc_beat == RESIDUE) && !beat_len_err) begin
          good_inc = 1'b1;
        end else begin
          bad_inc = 2'd1;
        end
      end
    end
  end

  logic [CNT_W:0]   good_sum, bad_sum;
  logic [CNT_W-1:0] good_sat, bad_sat;
  assign good_sum = {1'b0, good_cnt} + {{CNT_W{1'b0}}, good_inc};
  assign bad_sum  = {1'b0, bad_cnt} + {{(CNT_W-1){1'b0}}, bad_inc};
  assign good_sat = good_sum[CNT_W] ? CNT_MAX : good_sum[CNT_W-1:0];
  assign bad_sat  = bad_sum[CNT_W] ? CNT_MAX : bad_sum[CNT_W-1:0];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg    <= IDLE;
      crc_reg      <= CRC_SEED;
      len_reg      <= 16'd0;
      out_valid    <= 1'b0;
      out_sof      <= 1'b0;
      out_eof      <= 1'b0;
      out_odd      <= 1'b0;
      out_data     <= 16'd0;
      stat_valid   <= 1'b0;
      stat_fcs_ok  <= 1'b0;
      stat_len_err <= 1'b0;
      stat_abort   <= 1'b0;
      stat_len     <= 16'd0;
      good_cnt     <= '0;
      bad_cnt      <= '0;
    end else begin
      state_reg  <= state_next;
      crc_reg    <= crc_next;
      len_reg    <= len_next;
      out_valid  <= accept;
      out_sof    <= accept & in_sof;
      out_eof    <= accept & in_eof;
      out_odd    <= accept & in_odd;
      if (accept) begin
        out_data <= in_data;
      end
      stat_valid <= fire;
      if (fire) begin
        stat_fcs_ok  <= fire_ok;
        stat_len_err <= fire_len_err;
        stat_abort   <= fire_abort;
        stat_len     <= fire_len;
      end
      good_cnt <= good_sat;
      bad_cnt  <= bad_sat;
    end
  end
endmodule

// File: tb/tb_eth_fcs_check_d16.sv
// Directed bench for eth_fcs_check_d16: table of frames plus abort, saturation and reset sequences.
// Frame FCS values come from an independent LSB-first CRC-32 model.

module tb_eth_fcs_check_d16;
  localparam int CNT_W = 4;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic             in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0, in_odd = 1'b0;
  logic [15:0]      in_data = 16'd0;
  logic             out_valid, out_sof, out_eof, out_odd;
  logic [15:0]      out_data;
  logic             stat_valid, stat_fcs_ok, stat_len_err, stat_abort;
  logic [15:0]      stat_len;
  logic [CNT_W-1:0] good_cnt, bad_cnt;

  eth_fcs_check_d16 #(.MIN_LEN(64), .MAX_LEN(1518), .CNT_W(CNT_W)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .in_valid     (in_valid),
    .in_sof       (in_sof),
    .in_eof       (in_eof),
    .in_odd       (in_odd),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_sof      (out_sof),
    .out_eof      (out_eof),
    .out_odd      (out_odd),
    .out_data     (out_data),
    .stat_valid   (stat_valid),
    .stat_fcs_ok  (stat_fcs_ok),
    .stat_len_err (stat_len_err),
    .stat_abort   (stat_abort),
    .stat_len     (stat_len),
    .good_cnt     (good_cnt),
    .bad_cnt      (bad_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  logic        exp_v = 1'b0, exp_sof = 1'b0, exp_eof = 1'b0, exp_odd = 1'b0;
  logic [15:0] exp_data = 16'd0;

  typedef struct {
    logic        ok;
    logic        abort;
    logic        len_err;
    logic [15:0] len;
    logic [31:0] good;
    logic [31:0] bad;
  } stat_t;
  stat_t stat_q[$];

  typedef struct {
    int   len;
    int   flip;
    int   stray;
    logic ok;
    logic len_err;
    int   good;
    int   bad;
  } vec_t;
  vec_t vecs[8];

  logic [7:0] frame [0:1599];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge, check last cycle's forwarded beat, collect any status
  task automatic tick();
    stat_t s;
    @(negedge sys_clk);
    chk("out_valid", 32'(out_valid), 32'(exp_v));
    if (exp_v) begin
      chk("out_data", 32'(out_data), 32'(exp_data));
      chk("out_flags", 32'({out_sof, out_eof, out_odd}), 32'({exp_sof, exp_eof, exp_odd}));
    end
    if (stat_valid) begin
      s.ok      = stat_fcs_ok;
      s.abort   = stat_abort;
      s.len_err = stat_len_err;
      s.len     = stat_len;
      s.good    = 32'(good_cnt);
      s.bad     = 32'(bad_cnt);
      stat_q.push_back(s);
    end
  endtask

  task automatic drive_beat(input logic v, input logic s, input logic e, input logic o,
                            input logic [15:0] d, input logic acc);
    tick();
    in_valid = v;
    in_sof   = s;
    in_eof   = e;
    in_odd   = o;
    in_data  = d;
    exp_v    = acc;
    exp_sof  = s;
    exp_eof  = e;
    exp_odd  = o;
    exp_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_beat(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
  endtask

  function automatic logic [31:0] ref_fcs(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, frame[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // cut > 0: send only the first cut beats and leave the frame open
  task automatic send_frame(input int n, input int flip, input int cut);
    logic [31:0] f;
    logic [7:0]  hi;
    int          nb;
    for (int i = 0; i < n - 4; i++) frame[i] = (i < 9) ? 8'(8'h31 + i) : 8'h00;
    if (n == 13) begin
      f = 32'hCBF4_3926;
    end else begin
      f = ref_fcs(n - 4);
    end
    frame[n-4] = f[7:0];
    frame[n-3] = f[15:8];
    frame[n-2] = f[23:16];
    frame[n-1] = f[31:24];
    if (flip >= 0) frame[flip] = frame[flip] ^ 8'h01;
    nb = (n + 1) / 2;
    for (int b = 0; b < nb; b++) begin
      if (cut > 0 && b == cut) break;
      hi = (2 * b + 1 < n) ? frame[2*b+1] : 8'h00;
      drive_beat(1'b1, b == 0, b == nb - 1, (b == nb - 1) && (n % 2 == 1), {hi, frame[2*b]}, 1'b1);
    end
  endtask

  task automatic check_status(input string tag, input logic ok, input logic abort, input logic len_err,
                              input int len, input int good, input int bad);
    stat_t s;
    if (stat_q.size() == 0) begin
      chk({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      s = stat_q.pop_front();
      chk({tag, "_fcs_ok"}, 32'(s.ok), 32'(ok));
      chk({tag, "_abort"}, 32'(s.abort), 32'(abort));
      chk({tag, "_len_err"}, 32'(s.len_err), 32'(len_err));
      chk({tag, "_len"}, 32'(s.len), 32'(len));
      chk({tag, "_good"}, s.good, 32'(good));
      chk({tag, "_bad"}, s.bad, 32'(bad));
      $display("frame %s: ok=%0d abort=%0d len=%0d len_err=%0d good=%0d bad=%0d",
               tag, s.ok, s.abort, s.len, s.len_err, s.good, s.bad);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // len, flip byte, stray beats, fcs_ok, len_err, good_cnt, bad_cnt after the frame
    vecs[0] = '{13,   -1, 0, 1'b1, 1'b1, 0, 1};
    vecs[1] = '{64,   -1, 0, 1'b1, 1'b0, 1, 1};
    vecs[2] = '{64,   10, 0, 1'b0, 1'b0, 1, 2};
    vecs[3] = '{1600, -1, 3, 1'b1, 1'b1, 1, 3};
    vecs[4] = '{65,   -1, 0, 1'b1, 1'b0, 2, 3};
    vecs[5] = '{1518, -1, 0, 1'b1, 1'b0, 3, 3};
    vecs[6] = '{1519, -1, 0, 1'b1, 1'b1, 3, 4};
    vecs[7] = '{63,   -1, 0, 1'b1, 1'b1, 3, 5};

    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_stat", 32'({stat_valid, stat_fcs_ok, stat_len_err, stat_abort}), 32'd0);
    chk("rst_stat_len", 32'(stat_len), 32'd0);
    chk("rst_counts", 32'({good_cnt, bad_cnt}), 32'd0);
    sys_rst_n = 1'b1;
    idle(2);

    for (int v = 0; v < 8; v++) begin
      for (int s = 0; s < vecs[v].stray; s++) drive_beat(1'b1, 1'b0, 1'b0, 1'b0, 16'hA5A5, 1'b0);
      idle(1);
      chk("stray_status", 32'(stat_q.size()), 32'd0);
      send_frame(vecs[v].len, vecs[v].flip, 0);
      idle(2);
      chk("table_pulses", 32'(stat_q.size()), 32'd1);
      check_status($sformatf("vec%0d", v), vecs[v].ok, 1'b0, vecs[v].len_err,
                   vecs[v].len, vecs[v].good, vecs[v].bad);
      stat_q.delete();
    end

    // sof on beat 5 of an open frame, followed by a complete good frame
    send_frame(64, -1, 4);
    send_frame(64, -1, 0);
    idle(2);
    chk("abort_pulses", 32'(stat_q.size()), 32'd2);
    check_status("abort", 1'b0, 1'b1, 1'b1, 8, 3, 6);
    check_status("after_abort", 1'b1, 1'b0, 1'b0, 64, 4, 6);
    stat_q.delete();

    // sof+eof while active: one abort pulse, two frames counted bad
    send_frame(64, -1, 4);
    drive_beat(1'b1, 1'b1, 1'b1, 1'b0, 16'h1234, 1'b1);
    idle(3);
    chk("sof_eof_pulses", 32'(stat_q.size()), 32'd1);
    check_status("sof_eof", 1'b0, 1'b1, 1'b1, 8, 4, 8);
    stat_q.delete();

    for (int k = 0; k < 18; k++) begin
      send_frame(64, -1, 0);
      idle(2);
      check_status($sformatf("sat%0d", k), 1'b1, 1'b0, 1'b0, 64, (4 + k + 1 > 15) ? 15 : 4 + k + 1, 8);
      stat_q.delete();
    end
    chk("good_saturated", 32'(good_cnt), 32'hF);

    // reset in the middle of a frame
    send_frame(64, -1, 10);
    tick();
    sys_rst_n = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_eof = 1'b0;
    in_odd = 1'b0;
    in_data = 16'd0;
    exp_v = 1'b0;
    #1;
    chk("mid_rst_out", 32'({out_valid, out_sof, out_eof, out_odd, out_data}), 32'd0);
    chk("mid_rst_stat", 32'({stat_valid, stat_fcs_ok, stat_len_err, stat_abort, stat_len}), 32'd0);
    chk("mid_rst_counts", 32'({good_cnt, bad_cnt}), 32'd0);
    repeat (2) tick();
    sys_rst_n = 1'b1;
    idle(3);
    chk("post_rst_status", 32'(stat_q.size()), 32'd0);
    send_frame(64, -1, 0);
    idle(2);
    check_status("post_rst", 1'b1, 1'b0, 1'b0, 64, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
